load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: none; all widths are fixed at RV32I (32-bit address and data).
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  execute stage presents a memory op.
REQ-005 req_ready  out  1  unit accepts an op this cycle.
REQ-006 req_is_store  in  1  1=STORE opcode, 0=LOAD opcode.
REQ-007 req_funct3  in  3  LOAD/STORE funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW encodings).
REQ-008 req_addr  in  32  effective byte address.
REQ-009 req_wdata  in  32  rs2 store data.
REQ-010 req_rd  in  5  load destination register.
REQ-011 stall  out  1  pipeline hold request.
REQ-012 flush  in  1  squash the in-flight op's response.
REQ-013 resp_valid  out  1  one-cycle completion pulse.
REQ-014 resp_rdata  out  32  extended load data (0 for stores and faults).
REQ-015 resp_rd  out  5  load rd (0 for stores and faults).
REQ-016 resp_misaligned  out  1  address not naturally aligned.
REQ-017 resp_illegal  out  1  funct3 not a legal LOAD/STORE encoding.
REQ-018 mem_req, mem_we  out  1 each  data-bus request and write enable.
REQ-019 mem_addr  out  32  word address {req_addr[31:2],2'b00}.
REQ-020 mem_wdata  out  32  lane-replicated store data.
REQ-021 mem_be  out  4  byte enables.
REQ-022 mem_ack  in  1  bus completion.
REQ-023 mem_rdata  in  32  read word, valid with mem_ack.

Function
REQ-024 FSM states IDLE, BUS, RESP; req_ready=1 only in IDLE; stall = req_valid & ~req_ready.
REQ-025 Accept on req_valid & req_ready; all request fields are latched at acceptance.
REQ-026 Legal funct3: loads 000, 001, 010, 100, 101; stores 000, 001, 010; any other value faults with resp_illegal=1.
REQ-027 Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0, gives resp_misaligned=1.
REQ-028 Faulting op: IDLE->RESP directly, with no bus cycle; illegal takes priority (misaligned=0 when illegal=1).
REQ-029 Legal op: IDLE->BUS; mem_req, mem_we, mem_addr, mem_wdata and mem_be are registered and held constant until the mem_ack cycle.
REQ-030 mem_ack is honoured in the first BUS cycle; mem_ack outside BUS is ignored.
REQ-031 BUS->RESP on mem_ack; mem_req deasserts the next cycle; load data is captured from mem_rdata at mem_ack.
REQ-032 RESP lasts exactly one cycle, then returns to IDLE.
REQ-033 Minimum latency: accept at N, mem_req at N+1, ack at N+1, resp_valid at N+2; next accept at N+3.
REQ-034 Store lanes: SB: be=1<<addr[1:0], wdata={4{wdata[7:0]}}. SH: be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}. SW: be=1111.
REQ-035 Loads: mem_be=1111; the byte/half is selected by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
REQ-036 flush in BUS sets a kill flag: the bus transaction still completes, but resp_valid is suppressed.
REQ-037 flush during the RESP cycle gates resp_valid to 0 combinationally; flush in IDLE has no effect.
REQ-038 resp_* fields are valid only while resp_valid=1 and read 0 otherwise.

Reset
REQ-039 rst_n=0 forces IDLE immediately: mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-040 rst_n=0 also forces resp_valid=0, resp_* fields=0, kill flag=0, req_ready=1, stall=0.
REQ-041 Reset mid-BUS abandons the transaction; a late mem_ack after reset is ignored.

Verification
REQ-042 LB addr=0x1003, mem_rdata=0x80AABBCC, ack in the first BUS cycle -> resp_valid at N+2, resp_rdata=0xFFFFFF80, rd echoed.
REQ-043 SH addr=0x2002, wdata=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, mem_addr=0x2000; resp_rdata=0.
REQ-044 LW addr=0x0006 -> no mem_req, resp_misaligned=1 at N+1; funct3=011 load -> resp_illegal=1, misaligned=0.
REQ-045 LHU addr=0x10, ack delayed 5 cycles -> mem_* held stable, stall=1 for a second req_valid, mem_rdata=0x0000F00D gives resp_rdata=0x0000F00D.
REQ-046 flush while in BUS -> mem_ack completes the transaction, resp_valid stays 0, next op accepted normally.
REQ-047 rst_n low mid-BUS, then a late mem_ack -> outputs at reset values, no resp_valid.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding data-bus access, lane steering for stores,
// extraction and extension of load data, plus misaligned/illegal fault reporting.
//
// state  | meaning
// S_IDLE | ready for a new op; req_ready=1
// S_BUS  | bus request held until mem_ack
// S_RESP | one-cycle completion pulse (suppressed by the kill flag or by flush)
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        stall,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_misaligned,
  output logic        resp_illegal,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        kill_q, kill_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        mis_q, mis_d;
  logic        ill_q, ill_d;

  logic        accept;
  logic        legal;
  logic        misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_shifted;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign req_ready = (state_q == S_IDLE);
  assign stall     = req_valid & ~req_ready;
  assign accept    = req_valid & req_ready;

  always_comb begin
    legal = 1'b0;
    if (req_is_store) begin
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
              (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
  end

  assign misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                      ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << req_addr[1:0];
        st_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
      end
    endcase
  end

  // Load extraction uses the offset/funct3 latched at acceptance, not the live request.
  assign ld_shifted = mem_rdata >> {ld_off_q, 3'b000};
  assign ld_half    = ld_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_data = mem_rdata;
    case (ld_f3_q)
      3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_shifted[7:0]};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    kill_d      = kill_q;
    ld_f3_d     = ld_f3_q;
    ld_off_d    = ld_off_q;
    rdata_d     = rdata_q;
    rd_d        = rd_q;
    mis_d       = mis_q;
    ill_d       = ill_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          kill_d   = 1'b0;
          rdata_d  = 32'd0;
          ld_f3_d  = req_funct3;
          ld_off_d = req_addr[1:0];
          if (!legal) begin
            state_d = S_RESP;
            ill_d   = 1'b1;
            mis_d   = 1'b0;
            rd_d    = 5'd0;
          end else if (misaligned) begin
            state_d = S_RESP;
            ill_d   = 1'b0;
            mis_d   = 1'b1;
            rd_d    = 5'd0;
          end else begin
            state_d     = S_BUS;
            ill_d       = 1'b0;
            mis_d       = 1'b0;
            rd_d        = req_is_store ? 5'd0 : req_rd;
            mem_req_d   = 1'b1;
            mem_we_d    = req_is_store;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = req_is_store ? st_wdata : 32'd0;
            mem_be_d    = req_is_store ? st_be : 4'b1111;
          end
        end
      end
      S_BUS: begin
        if (flush) begin
          kill_d = 1'b1;
        end
        if (mem_ack) begin
          state_d     = S_RESP;
          rdata_d     = mem_we_q ? 32'd0 : ld_data;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'd0;
          mem_wdata_d = 32'd0;
          mem_be_d    = 4'd0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      kill_q      <= 1'b0;
      ld_f3_q     <= 3'd0;
      ld_off_q    <= 2'd0;
      rdata_q     <= 32'd0;
      rd_q        <= 5'd0;
      mis_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      kill_q      <= kill_d;
      ld_f3_q     <= ld_f3_d;
      ld_off_q    <= ld_off_d;
      rdata_q     <= rdata_d;
      rd_q        <= rd_d;
      mis_q       <= mis_d;
      ill_q       <= ill_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

  // Response fields read zero whenever the pulse is absent, including when flush gates it.
  assign resp_valid      = (state_q == S_RESP) & ~kill_q & ~flush;
  assign resp_rdata      = resp_valid ? rdata_q : 32'd0;
  assign resp_rd         = resp_valid ? rd_q : 5'd0;
  assign resp_misaligned = resp_valid & mis_q;
  assign resp_illegal    = resp_valid & ill_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed spec scenarios followed by random ops,
// each compared against an arithmetic model of the RV32I load/store rules.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        stall, flush;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_misaligned, resp_illegal;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .stall(stall), .flush(flush),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: access size from funct3, alignment by modulo, lanes and extension by shifts/masks.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                output bit ill, output bit mis, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] ld);
    int     size;
    longint mask;
    longint v;
    if (st) ill = (f3 > 3'd2);
    else    ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = 1 << f3[1:0];
    mis  = !ill && ((addr % size) != 0);
    be   = st ? 4'(((1 << size) - 1) << (addr % 4)) : 4'hF;
    case (size)
      1:       wd = 32'(wdata[7:0]) * 32'h01010101;
      2:       wd = 32'(wdata[15:0]) * 32'h00010001;
      default: wd = wdata;
    endcase
    mask = (64'd1 << (8 * size)) - 64'd1;
    v    = (longint'(rdata) >> ((addr % 4) * 8)) & mask;
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
    ld = v[31:0];
  endfunction

  // Starts just after a rising edge with the unit idle; ends the same way.
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                        input int dly, input bit fl_bus, input bit fl_resp, input bit hold2);
    bit          ill, mis;
    logic [3:0]  be;
    logic [31:0] wd, ld;
    model(st, f3, addr, wdata, rdata, ill, mis, be, wd, ld);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(negedge clk);
    chk("ready_idle", req_ready, 1'b1);
    chk("stall_idle", stall, 1'b0);
    @(posedge clk); #1;
    req_valid = hold2;
    req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    if (ill || mis) begin
      flush = fl_resp;
      @(negedge clk);
      chk("fault_no_memreq", mem_req, 1'b0);
      chk("fault_resp_valid", resp_valid, !fl_resp);
      chk("fault_illegal", resp_illegal, ill && !fl_resp);
      chk("fault_misaligned", resp_misaligned, mis && !fl_resp);
      chk("fault_rdata", resp_rdata, 32'd0);
      chk("fault_rd", resp_rd, 5'd0);
      chk("fault_stall", stall, hold2);
      @(posedge clk); #1;
      flush = 1'b0;
    end else begin
      for (int c = 0; c <= dly; c++) begin
        flush = fl_bus && (c == 0);
        if (c == dly) begin mem_ack = 1'b1; mem_rdata = rdata; end
        else mem_rdata = $urandom;
        @(negedge clk);
        chk("bus_req", mem_req, 1'b1);
        chk("bus_we", mem_we, st);
        chk("bus_addr", mem_addr, {addr[31:2], 2'b00});
        chk("bus_be", mem_be, be);
        if (st) chk("bus_wdata", mem_wdata, wd);
        chk("bus_no_resp", resp_valid, 1'b0);
        if (hold2) chk("bus_stall", stall, 1'b1);
        @(posedge clk); #1;
        flush = 1'b0; mem_ack = 1'b0; mem_rdata = $urandom;
      end
      req_valid = 1'b0;
      flush = fl_resp;
      @(negedge clk);
      chk("resp_memreq_low", mem_req, 1'b0);
      chk("resp_valid", resp_valid, !(fl_bus || fl_resp));
      chk("resp_rdata", resp_rdata, (st || fl_bus || fl_resp) ? 32'd0 : ld);
      chk("resp_rd", resp_rd, (st || fl_bus || fl_resp) ? 5'd0 : rd);
      chk("resp_flags", {resp_illegal, resp_misaligned}, 2'b00);
      @(posedge clk); #1;
      flush = 1'b0;
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("back_idle_ready", req_ready, 1'b1);
    chk("back_idle_noresp", resp_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0;
    req_wdata = 32'd0; req_rd = 5'd0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    #3;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_stall", stall, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_mem", {mem_req, mem_we, mem_be}, 6'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 3'b000, 32'h1003, 32'h0, 5'd7, 32'h80AABBCC, 0, 1'b0, 1'b0, 1'b0);
    chk("lb_model_const", resp_rdata, 32'd0);
    run_op(1'b1, 3'b001, 32'h2002, 32'h1234ABCD, 5'd3, 32'hDEADBEEF, 0, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 3'b010, 32'h0006, 32'h0, 5'd9, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 3'b011, 32'h0008, 32'h0, 5'd9, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 3'b100, 32'h0008, 32'h55, 5'd1, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 3'b101, 32'h0010, 32'h0, 5'd12, 32'h0000F00D, 5, 1'b0, 1'b0, 1'b1);
    run_op(1'b0, 3'b010, 32'h0020, 32'h0, 5'd4, 32'hCAFEF00D, 2, 1'b1, 1'b0, 1'b0);
    run_op(1'b0, 3'b010, 32'h0024, 32'h0, 5'd5, 32'h12345678, 0, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 3'b000, 32'h0031, 32'hA5, 5'd2, 32'h0, 1, 1'b0, 1'b1, 1'b0);

    // Stray ack and flush while idle must not produce anything.
    mem_ack = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("idle_ack_noresp", resp_valid, 1'b0);
    chk("idle_ack_noreq", mem_req, 1'b0);
    @(posedge clk); #1;
    mem_ack = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_ack_after", {resp_valid, req_ready}, 2'b01);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      run_op(1'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom), $urandom,
             int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of a bus access, followed by a late ack.
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'h11223344; req_rd = 5'd6;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("prerst_req", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem", {mem_req, mem_we, mem_be}, 6'd0);
    chk("midrst_addr", mem_addr, 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    chk("midrst_ready", {req_ready, stall, resp_valid}, 3'b100);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("late_ack_noresp", resp_valid, 1'b0);
    chk("late_ack_noreq", mem_req, 1'b0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_idle", {resp_valid, req_ready, resp_rdata[4:0]}, 7'b0100000);
    @(posedge clk); #1;
    run_op(1'b0, 3'b001, 32'h0042, 32'h0, 5'd31, 32'h8001_7FFF, 0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
